// File: rtl/axis_fifo_lite_reader.sv
// -----------------------------------------------------------------------------
// axis_fifo_lite_reader
//
// Buffers AXI4-Stream words (with their TLAST) in an internal FIFO and lets a
// processor drain them through a four-register AXI4-Lite slave window.
// Besides the data pop port it reports occupancy/status, exposes the TLAST
// flag of the head word, supports a one-shot flush, keeps a sticky underflow
// flag and raises a level interrupt once occupancy reaches a threshold.
//
// Register window (byte offsets):
//   0x0 DATA   RO  read pops the head word, returns it zero-extended
//                  (returns 0 and sets UNDERFLOW when empty)
//   0x4 STATUS RO  [0] empty [1] full [2] underflow [3] irq [4] head tlast
//                  [16 +: CNT_W] count
//   0x8 CTRL   RW  [0] flush (one-shot) [1] irq enable [2] underflow clear
//   0xC THRESH RW  [CNT_W-1:0] interrupt level threshold
//
// Ports:
//   ACLK, ARESETN            clock, asynchronous active-low reset
//   s_axis_*                 stream slave (tdata, tlast, tvalid, tready)
//   s_axi_aw*/w*/b*          AXI4-Lite write address/data/response channels
//   s_axi_ar*/r*             AXI4-Lite read address/data channels
//   irq                      registered level interrupt
// -----------------------------------------------------------------------------
module axis_fifo_lite_reader #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH         = 512
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  // Stream slave
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  // AXI4-Lite write channels
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  // AXI4-Lite read channels
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  // Interrupt
  output logic                            irq
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int TDW   = C_AXIS_TDATA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_THRESH = 2'd3
  } reg_sel_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TDW:0]       mem_q [FIFO_DEPTH];   // {tlast, tdata}
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               tready_en_q;          // holds tready low for the first cycle out of reset
  logic               flush_q;
  logic               irq_en_q;
  logic               underflow_q;
  logic [CNT_W-1:0]   thresh_q, thresh_d;
  logic               irq_q;

  logic               awready_q, bvalid_q;
  logic               arready_q, rvalid_q;
  logic [DW-1:0]      rdata_q, rdata_d;

  // ---------------------------------------------------------------------------
  // FIFO status and handshakes
  // ---------------------------------------------------------------------------
  logic               full, empty, push, pop, underflow_set;
  logic               wr_hs, rd_hs, ctrl_wr;
  logic [TDW:0]       head;
  reg_sel_e           wr_sel, rd_sel;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Flush cycle also blocks pushes so nothing is accepted and then discarded.
  assign s_axis_tready = tready_en_q && !full && !flush_q;
  assign push          = s_axis_tvalid && s_axis_tready;

  assign wr_sel  = reg_sel_e'(s_axi_awaddr[3:2]);
  assign rd_sel  = reg_sel_e'(s_axi_araddr[3:2]);
  assign wr_hs   = awready_q && s_axi_awvalid && s_axi_wvalid;
  assign rd_hs   = arready_q && s_axi_arvalid;
  assign ctrl_wr = wr_hs && (wr_sel == REG_CTRL) && s_axi_wstrb[0];

  // The pop is committed at the address handshake, so the word is consumed
  // even if the master is slow to take the read response.
  assign pop           = rd_hs && (rd_sel == REG_DATA) && !empty;
  assign underflow_set = rd_hs && (rd_sel == REG_DATA) && empty;

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; emptiness is defined by the
  // pointers and count, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tready_en_q <= 1'b0;
    end else begin
      tready_en_q <= 1'b1;
      if (flush_q) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers, underflow flag and interrupt
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    thresh_d = thresh_q;
    if (wr_hs && (wr_sel == REG_THRESH)) begin
      for (int i = 0; i < CNT_W; i++) begin
        if (s_axi_wstrb[i/8]) thresh_d[i] = s_axi_wdata[i];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      flush_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      underflow_q <= 1'b0;
      thresh_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      // Flush is a one-cycle strobe: set by the write, gone the cycle after.
      flush_q  <= ctrl_wr && s_axi_wdata[0];
      thresh_q <= thresh_d;
      if (ctrl_wr) irq_en_q <= s_axi_wdata[1];
      // A new underflow wins over a clear landing on the same edge.
      if (underflow_set)                 underflow_q <= 1'b1;
      else if (ctrl_wr && s_axi_wdata[2]) underflow_q <= 1'b0;
      irq_q <= irq_en_q && (thresh_q != '0) && (count_q >= thresh_q);
    end
  end

  assign irq = irq_q;

  // ---------------------------------------------------------------------------
  // AXI4-Lite write channel
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      // One-cycle ready pulse; the !awready_q term ends the pulse.
      awready_q <= s_axi_awvalid && s_axi_wvalid && !bvalid_q && !awready_q;
      if (wr_hs)             bvalid_q <= 1'b1;
      else if (s_axi_bready) bvalid_q <= 1'b0;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;

  // ---------------------------------------------------------------------------
  // AXI4-Lite read channel
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_d = '0;
    unique case (rd_sel)
      REG_DATA: begin
        if (!empty) rdata_d = DW'(head[TDW-1:0]);
      end
      REG_STATUS: begin
        rdata_d[0]            = empty;
        rdata_d[1]            = full;
        rdata_d[2]            = underflow_q;
        rdata_d[3]            = irq_q;
        rdata_d[4]            = head[TDW] && !empty;
        rdata_d[16 +: CNT_W]  = count_q;
      end
      REG_CTRL: begin
        rdata_d[0] = flush_q;
        rdata_d[1] = irq_en_q;
      end
      REG_THRESH: begin
        rdata_d[CNT_W-1:0] = thresh_q;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= s_axi_arvalid && !rvalid_q && !arready_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;

  // Address byte-lane bits and the unused upper write-data bits carry no meaning.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_wstrb};

endmodule

// File: tb/tb_axis_fifo_lite_reader.sv
// -----------------------------------------------------------------------------
// Self-checking bench for axis_fifo_lite_reader. A queue-based model tracks
// FIFO contents, the underflow flag, irq enable and threshold; register reads
// and popped data are compared against it.
// -----------------------------------------------------------------------------
module tb_axis_fifo_lite_reader;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [3:0]  s_axi_awaddr;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [32:0] fifo_m [$];
  logic        underflow_m;
  logic        irq_en_m;
  logic [CNT_W-1:0] thresh_m;

  axis_fifo_lite_reader #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .C_AXIS_TDATA_WIDTH (32),
    .FIFO_DEPTH         (DEPTH)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .irq           (irq)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Model helpers
  // ---------------------------------------------------------------------------
  function automatic void model_reset();
    fifo_m.delete();
    underflow_m = 1'b0;
    irq_en_m    = 1'b0;
    thresh_m    = '0;
  endfunction

  function automatic logic model_irq();
    return irq_en_m && (thresh_m != 0) && (fifo_m.size() >= int'(thresh_m));
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int n;
    n = fifo_m.size();
    s = '0;
    s[0] = (n == 0);
    s[1] = (n == DEPTH);
    s[2] = underflow_m;
    s[3] = model_irq();
    s[4] = (n != 0) ? fifo_m[0][32] : 1'b0;
    s[16 +: CNT_W] = CNT_W'(n);
    return s;
  endfunction

  function automatic logic [31:0] model_pop();
    logic [32:0] e;
    if (fifo_m.size() == 0) begin
      underflow_m = 1'b1;
      return 32'h0;
    end
    e = fifo_m.pop_front();
    return e[31:0];
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [31:0] d,
                                      input logic [3:0] strb);
    if (a[3:2] == 2'd2 && strb[0]) begin
      if (d[0]) fifo_m.delete();
      irq_en_m = d[1];
      if (d[2]) underflow_m = 1'b0;
    end else if (a[3:2] == 2'd3) begin
      for (int i = 0; i < CNT_W; i++) if (strb[i/8]) thresh_m[i] = d[i];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Bus tasks (entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic push_word(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    if (!s_axis_tready) begin
      errors++; checks++;
      $display("FAIL push_timeout: tready=%b required 1", s_axis_tready);
    end else begin
      @(negedge ACLK);
      fifo_m.push_back({l, d});
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] strb);
    int n;
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_wstrb   = strb;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!s_axi_awready && n < 50);
    if (!s_axi_awready) begin
      errors++; checks++;
      $display("FAIL aw_timeout: awready=%b required 1", s_axi_awready);
    end else begin
      @(negedge ACLK);
      model_write(a, d, strb);
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!s_axi_bvalid) begin
      errors++; checks++;
      $display("FAIL b_timeout: bvalid=%b required 1", s_axi_bvalid);
    end else begin
      s_axi_bready = 1'b1;
      @(negedge ACLK);
      s_axi_bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    d = '0;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!s_axi_arready && n < 50);
    if (!s_axi_arready) begin
      errors++; checks++;
      $display("FAIL ar_timeout: arready=%b required 1", s_axi_arready);
    end else begin
      @(negedge ACLK);
      if (!s_axi_rvalid) begin
        errors++; checks++;
        $display("FAIL rvalid_latency: rvalid=%b required 1", s_axi_rvalid);
      end
      d = s_axi_rdata;
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b1;
      @(negedge ACLK);
      s_axi_rready  = 1'b0;
    end
    s_axi_arvalid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] got;
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    checks++;
    if ({s_axis_tready, s_axi_awready, s_axi_wready, s_axi_bvalid,
         s_axi_arready, s_axi_rvalid, irq} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {s_axis_tready, s_axi_awready, s_axi_wready, s_axi_bvalid,
                s_axi_arready, s_axi_rvalid, irq});
    end
    checks++;
    if (s_axi_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h required 0", s_axi_rdata);
    end
    ARESETN = 1'b1;
    model_reset();
    @(negedge ACLK);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL tready_after_reset: got %b required 1", s_axis_tready);
    end
    axi_read(4'h4, got);
    checks++;
    if (got !== 32'h0000_0001) begin
      errors++; $display("FAIL reset_status: got %h required 00000001", got);
    end
    checks++;
    if (s_axi_rresp !== 2'b00 || s_axi_bresp !== 2'b00) begin
      errors++; $display("FAIL resp_okay: got %b/%b required 00/00", s_axi_rresp, s_axi_bresp);
    end
  endtask

  task automatic test_order_tlast();
    logic [31:0] words [4];
    logic [31:0] got, exp, st;
    words[0] = 32'h0101FFFF; words[1] = 32'hABCD0001;
    words[2] = 32'hDEAD0011; words[3] = 32'hBEEF0011;
    for (int i = 0; i < 4; i++) push_word(words[i], i == 3);
    axi_read(4'h4, got);
    exp = exp_status();
    checks++;
    if (got !== exp || got[16 +: CNT_W] !== CNT_W'(4)) begin
      errors++; $display("FAIL status_count4: got %h required %h", got, exp);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'h4, st);
      checks++;
      if (st[4] !== (i == 3)) begin
        errors++; $display("FAIL head_tlast[%0d]: got %b required %b", i, st[4], i == 3);
      end
      axi_read(4'h0, got);
      exp = model_pop();
      checks++;
      if (got !== exp || got !== words[i]) begin
        errors++; $display("FAIL pop_order[%0d]: got %h required %h", i, got, words[i]);
      end
    end
  endtask

  task automatic test_full_wrap();
    logic [31:0] got, exp, d;
    int n;
    for (int i = 0; i < DEPTH; i++) push_word($urandom, 1'($urandom));
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++; $display("FAIL full_tready: got %b required 0", s_axis_tready);
    end
    // Offer a word while full; it must not be taken.
    s_axis_tdata = 32'hBAD0BAD0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    repeat (3) @(negedge ACLK);
    s_axis_tvalid = 1'b0;
    axi_read(4'h4, got);
    exp = exp_status();
    checks++;
    if (got !== exp || got[1] !== 1'b1) begin
      errors++; $display("FAIL full_status: got %h required %h", got, exp);
    end
    axi_read(4'h0, got);
    exp = model_pop();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL pop_from_full: got %h required %h", got, exp);
    end
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL reopen_tready: got %b required 1", s_axis_tready);
    end
    // Push and pop on the same clock edge.
    s_axi_araddr = 4'h0; s_axi_arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!s_axi_arready && n < 50);
    checks++;
    if (!s_axi_arready || !s_axis_tready) begin
      errors++;
      $display("FAIL same_cycle_setup: arready=%b tready=%b required 1/1",
               s_axi_arready, s_axis_tready);
      s_axi_arvalid = 1'b0;
    end else begin
      d = $urandom;
      s_axis_tdata = d; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
      @(negedge ACLK);
      s_axis_tvalid = 1'b0; s_axi_arvalid = 1'b0;
      got = s_axi_rdata;
      exp = model_pop();
      fifo_m.push_back({1'b0, d});
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL same_cycle_pop: got %h required %h", got, exp);
      end
      s_axi_rready = 1'b1;
      @(negedge ACLK);
      s_axi_rready = 1'b0;
    end
    axi_read(4'h4, got);
    exp = exp_status();
    checks++;
    if (got !== exp || got[16 +: CNT_W] !== CNT_W'(DEPTH - 1)) begin
      errors++; $display("FAIL same_cycle_count: got %h required %h", got, exp);
    end
    // Second lap to move both pointers across the wrap point again.
    for (int lap = 0; lap < 2; lap++) begin
      while (fifo_m.size() > 0) begin
        axi_read(4'h0, got);
        exp = model_pop();
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL wrap_pop: got %h required %h", got, exp);
        end
      end
      n = $urandom_range(3, DEPTH);
      for (int i = 0; i < n; i++) push_word($urandom, 1'($urandom));
    end
    while (fifo_m.size() > 0) begin
      axi_read(4'h0, got);
      exp = model_pop();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL wrap_drain: got %h required %h", got, exp);
      end
    end
  endtask

  task automatic test_underflow();
    logic [31:0] got, exp;
    axi_read(4'h0, got);
    exp = model_pop();
    checks++;
    if (got !== exp || got !== 32'h0) begin
      errors++; $display("FAIL empty_pop_data: got %h required 0", got);
    end
    axi_read(4'h4, got);
    exp = exp_status();
    checks++;
    if (got !== exp || got !== 32'h0000_0005) begin
      errors++; $display("FAIL underflow_set: got %h required 00000005", got);
    end
    axi_write(4'h8, 32'h4, 4'hF);
    axi_read(4'h4, got);
    exp = exp_status();
    checks++;
    if (got !== exp || got !== 32'h0000_0001) begin
      errors++; $display("FAIL underflow_clear: got %h required 00000001", got);
    end
    axi_read(4'h8, got);
    checks++;
    if (got !== 32'h0) begin
      errors++; $display("FAIL ctrl_readback: got %h required 0", got);
    end
  endtask

  task automatic test_irq();
    logic [31:0] got, exp;
    axi_write(4'hC, 32'd3, 4'hF);
    axi_write(4'h8, 32'h2, 4'hF);
    push_word($urandom, 1'b0);
    push_word($urandom, 1'b0);
    repeat (2) @(negedge ACLK);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_below: got %b required 0", irq);
    end
    push_word($urandom, 1'b0);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_registered: got %b required 0", irq);
    end
    @(negedge ACLK);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_rise: got %b required 1", irq);
    end
    axi_read(4'h4, got);
    exp = exp_status();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL irq_status: got %h required %h", got, exp);
    end
    axi_read(4'h0, got);
    exp = model_pop();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL irq_pop: got %h required %h", got, exp);
    end
    checks++;
    if (irq !== model_irq()) begin
      errors++; $display("FAIL irq_fall: got %b required %b", irq, model_irq());
    end
    // Byte strobes: a write with no strobes must not change THRESH.
    axi_write(4'hC, 32'h0000_0FFF, 4'h0);
    axi_read(4'hC, got);
    checks++;
    if (got !== {{(32-CNT_W){1'b0}}, thresh_m} || got !== 32'd3) begin
      errors++; $display("FAIL thresh_nostrb: got %h required 00000003", got);
    end
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF);
    axi_read(4'hC, got);
    checks++;
    if (got !== {{(32-CNT_W){1'b0}}, thresh_m}) begin
      errors++; $display("FAIL thresh_width: got %h required %h", got, thresh_m);
    end
    // Random threshold / enable / level combinations.
    for (int it = 0; it < 4; it++) begin
      int k;
      axi_write(4'hC, 32'($urandom_range(0, DEPTH)), 4'hF);
      axi_write(4'h8, {30'b0, 1'($urandom), 1'b0}, 4'h1);
      k = $urandom_range(0, DEPTH - fifo_m.size());
      for (int i = 0; i < k; i++) push_word($urandom, 1'($urandom));
      repeat (2) @(negedge ACLK);
      checks++;
      if (irq !== model_irq()) begin
        errors++; $display("FAIL irq_rand[%0d]: got %b required %b", it, irq, model_irq());
      end
      axi_read(4'h4, got);
      exp = exp_status();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL status_rand[%0d]: got %h required %h", it, got, exp);
      end
      while (fifo_m.size() > 0) begin
        axi_read(4'h0, got);
        exp = model_pop();
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL rand_drain: got %h required %h", got, exp);
        end
      end
    end
    axi_write(4'h8, 32'h0, 4'hF);
    axi_write(4'hC, 32'h0, 4'hF);
  endtask

  task automatic test_flush();
    logic [31:0] got, exp;
    int low;
    for (int i = 0; i < 10; i++) push_word($urandom, 1'($urandom));
    low = 0;
    fork
      axi_write(4'h8, 32'h1, 4'hF);
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge ACLK);
          if (!s_axis_tready) low++;
        end
      end
    join
    checks++;
    if (low !== 1) begin
      errors++; $display("FAIL flush_tready_low: got %0d cycles required 1", low);
    end
    axi_read(4'h4, got);
    exp = exp_status();
    checks++;
    if (got !== exp || got !== 32'h0000_0001) begin
      errors++; $display("FAIL flush_status: got %h required 00000001", got);
    end
    axi_read(4'h8, got);
    checks++;
    if (got !== 32'h0) begin
      errors++; $display("FAIL flush_ctrl_readback: got %h required 0", got);
    end
    for (int i = 0; i < 3; i++) push_word($urandom, 1'($urandom));
    while (fifo_m.size() > 0) begin
      axi_read(4'h0, got);
      exp = model_pop();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL after_flush_pop: got %h required %h", got, exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] got;
    axi_write(4'hC, 32'd2, 4'hF);
    for (int i = 0; i < 5; i++) push_word($urandom, 1'b0);
    #2 ARESETN = 1'b0;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL async_reset: tready=%b irq=%b required 0/0", s_axis_tready, irq);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    model_reset();
    @(negedge ACLK);
    axi_read(4'h4, got);
    checks++;
    if (got !== exp_status()) begin
      errors++; $display("FAIL midreset_status: got %h required %h", got, exp_status());
    end
    axi_read(4'hC, got);
    checks++;
    if (got !== 32'h0) begin
      errors++; $display("FAIL midreset_thresh: got %h required 0", got);
    end
  endtask

  initial begin
    ARESETN       = 1'b0;
    s_axis_tdata  = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
    s_axi_awaddr  = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    model_reset();
    @(negedge ACLK);
    test_reset();
    test_order_tlast();
    test_full_wrap();
    test_underflow();
    test_irq();
    test_flush();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
